db_top_buf: RTL and testbench

//  Deblocking top-pixel line buffer for the current LCU (Y/Cb/Cr rows), single clock.
//  Two access ports with byte-lane writes, optional output register, defined collision

---
 rtl/db_pkg.sv | 11 +
 rtl/db_top_buf_if.sv | 49 ++++
 rtl/db_top_buf_rdpipe.sv | 56 +++++
 rtl/db_top_buf.sv | 152 +++++++++++++++
 tb/tb_db_top_buf.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/db_pkg.sv
// Shared constants for the deblocking top-pixel line buffer.
package db_pkg;

    localparam int unsigned DB_TOP_DW = 128;
    localparam int unsigned DB_TOP_AW = 5;

    // Clear FSM state encodings
    localparam logic [0:0] DB_CLR_IDLE = 1'b0;
    localparam logic [0:0] DB_CLR_BUSY = 1'b1;

endpackage

// File: rtl/db_top_buf_if.sv
// Two-port access bus of the top-pixel line buffer, with clear control.
interface db_top_buf_if
    import db_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DB_TOP_DW,
    parameter int unsigned ADDR_WIDTH = DB_TOP_AW
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  clr_i;
    logic                  busy_o;

    logic                  cena_i;
    logic                  wena_i;
    logic [BE_WIDTH-1:0]   bwena_i;
    logic [ADDR_WIDTH-1:0] addra_i;
    logic [DATA_WIDTH-1:0] dataa_i;
    logic [DATA_WIDTH-1:0] dataa_o;
    logic                  valida_o;

    logic                  cenb_i;
    logic                  wenb_i;
    logic [BE_WIDTH-1:0]   bwenb_i;
    logic [ADDR_WIDTH-1:0] addrb_i;
    logic [DATA_WIDTH-1:0] datab_i;
    logic [DATA_WIDTH-1:0] datab_o;
    logic                  validb_o;

    // Requester side (filter core / fetch-store logic)
    modport master (
        output clr_i,
        input  busy_o,
        output cena_i, wena_i, bwena_i, addra_i, dataa_i,
        input  dataa_o, valida_o,
        output cenb_i, wenb_i, bwenb_i, addrb_i, datab_i,
        input  datab_o, validb_o
    );

    // Buffer side
    modport slave (
        input  clr_i,
        output busy_o,
        input  cena_i, wena_i, bwena_i, addra_i, dataa_i,
        output dataa_o, valida_o,
        input  cenb_i, wenb_i, bwenb_i, addrb_i, datab_i,
        output datab_o, validb_o
    );

endinterface

// File: rtl/db_top_buf_rdpipe.sv
// Read-return pipeline: 1 + OUT_REG stages of valid strobe and held data.
module db_top_buf_rdpipe #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned OUT_REG    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // First stage: capture the read word, hold it while no read is returning
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            // Optional output stage, same hold behaviour
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign out_valid = s2_valid;
            assign out_data  = s2_data;
        end else begin : g_noreg
            assign out_valid = s1_valid;
            assign out_data  = s1_data;
        end
    endgenerate

endmodule

// File: rtl/db_top_buf.sv
// Deblocking top-pixel line buffer: two byte-lane ports, write-first
// collision handling, hardware clear FSM and registered read return.
module db_top_buf
    import db_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DB_TOP_DW,
    parameter int unsigned ADDR_WIDTH = DB_TOP_AW,
    parameter int unsigned OUT_REG    = 1,
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic        clk,
    input  logic        rst,
    db_top_buf_if.slave bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [0:0] RST_STATE = (CLR_ON_RST != 0) ? DB_CLR_BUSY : DB_CLR_IDLE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  busy_q;
    logic                  busy;

    logic                  wr_a;
    logic                  wr_b;
    logic                  rd_a;
    logic                  rd_b;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] rd_word_a;
    logic [DATA_WIDTH-1:0] rd_word_b;

    // Overlay the enabled (low-active) lanes of wr_word onto old_word
    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] wr_word,
        input logic [BE_WIDTH-1:0]   bwen
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < BE_WIDTH; k++) begin
            if (!bwen[k]) begin
                res[k*8 +: 8] = wr_word[k*8 +: 8];
            end
        end
        return res;
    endfunction

    assign busy      = (state == DB_CLR_BUSY);
    assign wr_a      = !busy && !bus.cena_i && !bus.wena_i;
    assign wr_b      = !busy && !bus.cenb_i && !bus.wenb_i;
    assign rd_a      = !busy && !bus.cena_i &&  bus.wena_i;
    assign rd_b      = !busy && !bus.cenb_i &&  bus.wenb_i;
    assign same_addr = (bus.addra_i == bus.addrb_i);

    // Clear FSM state and counter registers, plus registered busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RST_STATE;
            cnt    <= '0;
            busy_q <= (CLR_ON_RST != 0);
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_q <= (state_nxt == DB_CLR_BUSY);
        end
    end

    // Clear FSM next state: sweep every address once, ignore clr_i while busy
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            DB_CLR_IDLE: begin
                if (bus.clr_i) begin
                    state_nxt = DB_CLR_BUSY;
                    cnt_nxt   = '0;
                end
            end
            DB_CLR_BUSY: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = DB_CLR_IDLE;
                end
            end
            default: begin
                state_nxt = DB_CLR_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Memory update: clear sweep, else byte-lane writes with port B last so it wins shared lanes
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (wr_a && !bus.bwena_i[k]) begin
                    mem[bus.addra_i][k*8 +: 8] <= bus.dataa_i[k*8 +: 8];
                end
                if (wr_b && !bus.bwenb_i[k]) begin
                    mem[bus.addrb_i][k*8 +: 8] <= bus.datab_i[k*8 +: 8];
                end
            end
        end
    end

    // Write-first read words: forward the other port's same-address write lanes
    always_comb begin
        rd_word_a = mem[bus.addra_i];
        rd_word_b = mem[bus.addrb_i];
        if (wr_b && same_addr) begin
            rd_word_a = byte_merge(rd_word_a, bus.datab_i, bus.bwenb_i);
        end
        if (wr_a && same_addr) begin
            rd_word_b = byte_merge(rd_word_b, bus.dataa_i, bus.bwena_i);
        end
    end

    db_top_buf_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rdpipe_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_a),
        .in_data   (rd_word_a),
        .out_valid (bus.valida_o),
        .out_data  (bus.dataa_o)
    );

    db_top_buf_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rdpipe_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_b),
        .in_data   (rd_word_b),
        .out_valid (bus.validb_o),
        .out_data  (bus.datab_o)
    );

    assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_db_top_buf.sv
// Directed self-checking bench for db_top_buf (default parameters, OUT_REG=1).
module tb_db_top_buf;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 5;

    logic clk;
    logic rst;
    int   err_cnt;
    int   chk_cnt;

    db_top_buf_if bus ();

    db_top_buf u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", err_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        bus.cena_i  = 1'b1;
        bus.wena_i  = 1'b1;
        bus.bwena_i = '1;
        bus.addra_i = '0;
        bus.dataa_i = '0;
        bus.cenb_i  = 1'b1;
        bus.wenb_i  = 1'b1;
        bus.bwenb_i = '1;
        bus.addrb_i = '0;
        bus.datab_i = '0;
    endtask

    task automatic drive_wr(input bit pb, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [15:0] bwen);
        if (!pb) begin
            bus.cena_i = 1'b0; bus.wena_i = 1'b0; bus.addra_i = addr;
            bus.dataa_i = data; bus.bwena_i = bwen;
        end else begin
            bus.cenb_i = 1'b0; bus.wenb_i = 1'b0; bus.addrb_i = addr;
            bus.datab_i = data; bus.bwenb_i = bwen;
        end
    endtask

    task automatic drive_rd(input bit pb, input logic [AW-1:0] addr);
        if (!pb) begin
            bus.cena_i = 1'b0; bus.wena_i = 1'b1; bus.addra_i = addr;
        end else begin
            bus.cenb_i = 1'b0; bus.wenb_i = 1'b1; bus.addrb_i = addr;
        end
    endtask

    // Called right after the request edge; lat counts edges from request to strobe
    task automatic wait_valid(input bit pb, output logic [DW-1:0] data, output int lat);
        lat = 1;
        while (!(pb ? bus.validb_o : bus.valida_o) && lat < 8) begin
            tick();
            lat++;
        end
        data = pb ? bus.datab_o : bus.dataa_o;
    endtask

    task automatic wr(input bit pb, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [15:0] bwen);
        drive_wr(pb, addr, data, bwen);
        tick();
        idle_ports();
    endtask

    task automatic rd(input bit pb, input logic [AW-1:0] addr,
                      output logic [DW-1:0] data, output int lat);
        drive_rd(pb, addr);
        tick();
        idle_ports();
        wait_valid(pb, data, lat);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy_o && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] hold;
        int            lat;
        int            n;
        int            bad_lat;
        logic          any_valid;

        err_cnt = 0;
        chk_cnt = 0;
        rst = 1'b1;
        bus.clr_i = 1'b0;
        idle_ports();

        // Reset state
        #1;
        chk("rst_busy",   DW'(bus.busy_o),   DW'(1));
        chk("rst_valida", DW'(bus.valida_o), DW'(0));
        chk("rst_validb", DW'(bus.validb_o), DW'(0));
        chk("rst_dataa",  bus.dataa_o,       '0);
        chk("rst_datab",  bus.datab_o,       '0);

        // 1: automatic clear after reset release
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        count_busy(n);
        chk("auto_clr_cycles", DW'(n), DW'(32));
        bad_lat = 0;
        for (int a = 0; a < 32; a++) begin
            rd(1'b0, AW'(a), d, lat);
            if (lat != 2) bad_lat++;
            chk($sformatf("auto_clr_rd%0d", a), d, '0);
        end
        chk("auto_clr_lat", DW'(bad_lat), DW'(0));

        // 2: write then read on the other port, latency 2, data held after strobe
        wr(1'b0, 5'd3, 128'h000102030405060708090A0B0C0D0E0F, 16'h0000);
        drive_rd(1'b1, 5'd3);
        tick();
        idle_ports();
        chk("rd_lat1_valid", DW'(bus.validb_o), DW'(0));
        tick();
        chk("rd_lat2_valid", DW'(bus.validb_o), DW'(1));
        chk("rd_data",       bus.datab_o, 128'h000102030405060708090A0B0C0D0E0F);
        tick();
        chk("rd_strobe_end", DW'(bus.validb_o), DW'(0));
        chk("rd_hold",       bus.datab_o, 128'h000102030405060708090A0B0C0D0E0F);

        // 3: partial byte-lane write over existing word
        wr(1'b0, 5'd7, {16{8'hAA}}, 16'h0000);
        wr(1'b0, 5'd7, {16{8'h11}}, 16'hFF00);
        rd(1'b0, 5'd7, d, lat);
        chk("bwe_merge", d, {{8{8'hAA}}, {8{8'h11}}});
        chk("bwe_lat",   DW'(lat), DW'(2));

        // 4: write/write collision, shared lanes take port B
        drive_wr(1'b0, 5'd5, {16{8'h11}}, 16'h0000);
        drive_wr(1'b1, 5'd5, {16{8'h22}}, 16'h00FF);
        tick();
        idle_ports();
        rd(1'b1, 5'd5, d, lat);
        chk("ww_collision", d, {{8{8'h22}}, {8{8'h11}}});

        // 5: write-first forwarding in both directions
        drive_wr(1'b0, 5'd9, {16{8'h5A}}, 16'h0000);
        drive_rd(1'b1, 5'd9);
        tick();
        idle_ports();
        wait_valid(1'b1, d, lat);
        chk("wf_b_full", d, {16{8'h5A}});
        chk("wf_b_lat",  DW'(lat), DW'(2));

        drive_wr(1'b0, 5'd9, {16{8'hC3}}, 16'hFFF0);
        drive_rd(1'b1, 5'd9);
        tick();
        idle_ports();
        wait_valid(1'b1, d, lat);
        chk("wf_b_part", d, {{12{8'h5A}}, {4{8'hC3}}});

        drive_wr(1'b1, 5'd12, {16{8'h3C}}, 16'h0000);
        drive_rd(1'b0, 5'd12);
        tick();
        idle_ports();
        wait_valid(1'b0, d, lat);
        chk("wf_a_full", d, {16{8'h3C}});

        // Different addresses are independent
        drive_wr(1'b0, 5'd20, {16{8'h14}}, 16'h0000);
        drive_wr(1'b1, 5'd21, {16{8'h15}}, 16'h0000);
        tick();
        idle_ports();
        drive_rd(1'b0, 5'd21);
        drive_rd(1'b1, 5'd20);
        tick();
        idle_ports();
        wait_valid(1'b0, d, lat);
        chk("indep_a",       d, {16{8'h15}});
        chk("indep_b_valid", DW'(bus.validb_o), DW'(1));
        chk("indep_b",       bus.datab_o, {16{8'h14}});

        // 6a: requested clear with traffic and a repeated clr_i while busy
        hold = bus.dataa_o;
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        chk("clr_busy_rise", DW'(bus.busy_o), DW'(1));
        n = 0;
        any_valid = 1'b0;
        while (bus.busy_o && n < 100) begin
            if (n == 10) begin
                drive_wr(1'b0, 5'd3, {16{8'hFF}}, 16'h0000);
                drive_rd(1'b1, 5'd7);
                bus.clr_i = 1'b1;
            end else begin
                idle_ports();
                bus.clr_i = 1'b0;
            end
            tick();
            n++;
            any_valid = any_valid | bus.valida_o | bus.validb_o;
        end
        idle_ports();
        bus.clr_i = 1'b0;
        chk("clr_cycles",    DW'(n), DW'(32));
        chk("clr_no_valid",  DW'(any_valid), DW'(0));
        chk("clr_hold_a",    bus.dataa_o, hold);
        rd(1'b0, 5'd3, d, lat);
        chk("clr_drop_wr3",  d, '0);
        rd(1'b1, 5'd7, d, lat);
        chk("clr_rd7",       d, '0);
        rd(1'b0, 5'd20, d, lat);
        chk("clr_rd20",      d, '0);

        // 6b: reset at cnt=10 aborts, clear restarts from address 0
        wr(1'b1, 5'd31, {16{8'hEE}}, 16'h0000);
        wr(1'b0, 5'd15, {16{8'h77}}, 16'h0000);
        rd(1'b0, 5'd31, d, lat);
        chk("pre_rst_rd31", d, {16{8'hEE}});
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  DW'(bus.busy_o),   DW'(1));
        chk("mid_rst_dataa", bus.dataa_o,       '0);
        chk("mid_rst_valid", DW'(bus.valida_o), DW'(0));
        #1 rst = 1'b0;
        count_busy(n);
        chk("restart_cycles", DW'(n), DW'(32));
        for (int a = 0; a < 32; a++) begin
            rd(1'b1, AW'(a), d, lat);
            chk($sformatf("restart_rd%0d", a), d, '0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
